assert_ctl_responder: RTL and testbench



---
 rtl/assert_ctl_responder.sv | 141 ++++++++++++++
 tb/tb_assert_ctl_responder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/assert_ctl_responder.sv
// Assertion-control responder: gates per-source failure pulses with on/off/kill
// commands, coalesces them into pending bits and streams reports from a small FIFO.
module assert_ctl_responder #(
  parameter int NUM_SRC    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16,
  parameter int SRC_W      = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ctl_valid,
  output logic               ctl_ready,
  input  logic [1:0]         ctl_op,
  input  logic [NUM_SRC-1:0] ctl_mask,
  input  logic [NUM_SRC-1:0] fail_i,
  output logic               rpt_valid,
  input  logic               rpt_ready,
  output logic [SRC_W-1:0]   rpt_src,
  output logic [CNT_W-1:0]   rpt_seq,
  output logic [NUM_SRC-1:0] enabled_o,
  output logic [CNT_W-1:0]   drop_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, TURN} state_t;

  state_t             state;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] pending_nxt;
  logic [NUM_SRC-1:0] gated;
  logic [NUM_SRC-1:0] kill_mask;
  logic [NUM_SRC-1:0] cand;
  logic [NUM_SRC-1:0] deq;
  logic [SRC_W-1:0]   sel;
  logic               accept;
  logic               enq;
  logic               pop;
  logic               full;
  logic [CNT_W-1:0]   seq;
  logic [CNT_W-1:0]   ndrops;
  logic [CNT_W:0]     drop_sum;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;
  logic [SRC_W-1:0]   mem_src [FIFO_DEPTH];
  logic [CNT_W-1:0]   mem_seq [FIFO_DEPTH];

  assign accept    = ctl_valid && ctl_ready;
  assign kill_mask = (accept && ctl_op == 2'b11) ? ctl_mask : '0;
  assign gated     = fail_i & enabled_o;
  assign full      = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign rpt_valid = (count != '0);
  assign pop       = rpt_valid && rpt_ready;
  assign rpt_src   = rpt_valid ? mem_src[rd_ptr] : '0;
  assign rpt_seq   = rpt_valid ? mem_seq[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ctl_ready <= 1'b1;
      enabled_o <= '1;
    end else begin
      case (state)
        IDLE: begin
          if (ctl_valid) begin
            state     <= TURN;
            ctl_ready <= 1'b0;
            case (ctl_op)
              2'b01:   enabled_o <= enabled_o | ctl_mask;
              2'b10,
              2'b11:   enabled_o <= enabled_o & ~ctl_mask;
              default: enabled_o <= enabled_o;
            endcase
          end
        end
        default: begin
          state     <= IDLE;
          ctl_ready <= 1'b1;
        end
      endcase
    end
  end

  // A source being killed this edge is neither reported nor re-armed by a new failure.
  always_comb begin
    cand = pending & ~kill_mask;
    sel  = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand[i]) sel = SRC_W'(i);
    end
    enq = (|cand) && (!full || pop);
    deq = '0;
    if (enq) deq[sel] = 1'b1;
    pending_nxt = pending;
    ndrops      = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (kill_mask[i]) begin
        pending_nxt[i] = 1'b0;
      end else if (gated[i]) begin
        pending_nxt[i] = 1'b1;
        if (pending[i] && !deq[i]) ndrops = ndrops + CNT_W'(1);
      end else if (deq[i]) begin
        pending_nxt[i] = 1'b0;
      end
    end
    drop_sum = {1'b0, drop_cnt} + {1'b0, ndrops};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending  <= '0;
      drop_cnt <= '0;
      seq      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      pending  <= pending_nxt;
      drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
      if (enq) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        seq    <= seq + CNT_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      mem_src[wr_ptr] <= sel;
      mem_seq[wr_ptr] <= seq;
    end
  end

endmodule

// File: tb/tb_assert_ctl_responder.sv
// Randomized and directed bench for assert_ctl_responder; a reference model
// predicts reports into a queue that a negedge monitor drains and compares.
module tb_assert_ctl_responder;

  localparam int NS    = 4;
  localparam int DEPTH = 4;

  logic            clk;
  logic            rst_n;
  logic            ctl_valid;
  logic            ctl_ready;
  logic [1:0]      ctl_op;
  logic [NS-1:0]   ctl_mask;
  logic [NS-1:0]   fail_i;
  logic            rpt_valid;
  logic            rpt_ready;
  logic [1:0]      rpt_src;
  logic [15:0]     rpt_seq;
  logic [NS-1:0]   enabled_o;
  logic [15:0]     drop_cnt;

  assert_ctl_responder #(.NUM_SRC(NS), .FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .ctl_valid(ctl_valid), .ctl_ready(ctl_ready),
    .ctl_op(ctl_op), .ctl_mask(ctl_mask), .fail_i(fail_i), .rpt_valid(rpt_valid),
    .rpt_ready(rpt_ready), .rpt_src(rpt_src), .rpt_seq(rpt_seq),
    .enabled_o(enabled_o), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  bit monOn      = 0;

  // Model state: expected reports are src*65536+seq.
  int            expq [$];
  logic [NS-1:0] mEn;
  logic [NS-1:0] mPend;
  int            mOcc;
  int            mSeq;
  int            mDrops;
  bit            mBusy;
  int            h0, h1, h2;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelStep(input logic rst, input logic [NS-1:0] fail, input logic cv,
                           input logic [1:0] op, input logic [NS-1:0] mask, input logic rr);
    bit            accept;
    bit            popNow;
    int            pick;
    logic [NS-1:0] killM;
    logic [NS-1:0] deqM;
    if (rst) begin
      mEn = '1; mPend = '0; mOcc = 0; mSeq = 0; mDrops = 0; mBusy = 0;
      expq.delete();
      return;
    end
    accept = cv && !mBusy;
    killM  = (accept && op == 2'b11) ? mask : '0;
    popNow = (mOcc > 0) && rr;
    pick   = -1;
    for (int i = 0; i < NS; i++)
      if (pick < 0 && mPend[i] && !killM[i]) pick = i;
    deqM = '0;
    if (pick >= 0 && (mOcc < DEPTH || popNow)) begin
      expq.push_back(pick * 65536 + mSeq);
      mSeq = (mSeq + 1) % 65536;
      mOcc++;
      deqM[pick] = 1'b1;
    end
    if (popNow) mOcc--;
    for (int i = 0; i < NS; i++) begin
      if (killM[i]) mPend[i] = 1'b0;
      else if (fail[i] && mEn[i]) begin
        if (mPend[i] && !deqM[i]) mDrops = (mDrops < 65535) ? mDrops + 1 : 65535;
        mPend[i] = 1'b1;
      end else if (deqM[i]) mPend[i] = 1'b0;
    end
    if (accept) begin
      if (op == 2'b01) mEn = mEn | mask;
      else if (op != 2'b00) mEn = mEn & ~mask;
    end
    mBusy = accept;
  endtask

  task automatic applyStimulus(input logic rst, input logic [NS-1:0] fail, input logic cv,
                               input logic [1:0] op, input logic [NS-1:0] mask, input logic rr);
    @(posedge clk);
    #1;
    rst_n = !rst; fail_i = fail; ctl_valid = cv; ctl_op = op; ctl_mask = mask; rpt_ready = rr;
    @(negedge clk);
    #1;
    modelStep(rst, fail, cv, op, mask, rr);
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 2'b00, '0, rr);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((expq.size() != 0 || mPend != '0) && n < 300) begin
      applyStimulus(1'b0, '0, 1'b0, 2'b00, '0, 1'b1);
      n++;
    end
    checkOutput("drain_queue_empty", expq.size(), 0);
  endtask

  always @(negedge clk) begin
    if (monOn) begin
      checkOutput("rpt_valid", rpt_valid, expq.size() != 0);
      if (expq.size() != 0 && rpt_valid === 1'b1) begin
        checkOutput("rpt_src", rpt_src, expq[0] / 65536);
        checkOutput("rpt_seq", rpt_seq, expq[0] % 65536);
        if (rpt_ready) begin
          h0 = h1; h1 = h2; h2 = expq[0] % 65536;
          void'(expq.pop_front());
        end
      end
      checkOutput("ctl_ready", ctl_ready, !mBusy);
      checkOutput("enabled_o", enabled_o, mEn);
      checkOutput("drop_cnt", drop_cnt, mDrops);
    end
  end

  initial begin
    rst_n = 1'b0; ctl_valid = 1'b0; ctl_op = 2'b00; ctl_mask = '0; fail_i = '0; rpt_ready = 1'b0;
    applyStimulus(1'b1, '0, 1'b0, 2'b00, '0, 1'b1);
    applyStimulus(1'b1, '0, 1'b0, 2'b00, '0, 1'b1);
    monOn = 1;

    // Single failure latency
    applyStimulus(1'b0, 4'b0001, 1'b0, 2'b00, '0, 1'b1);
    idle(2, 1'b1);
    checkOutput("first_valid", rpt_valid, 1'b1);
    checkOutput("first_src", rpt_src, 0);
    checkOutput("first_seq", rpt_seq, 0);
    idle(1, 1'b1);
    checkOutput("first_valid_low", rpt_valid, 1'b0);
    checkOutput("first_drop", drop_cnt, 0);

    // Off with a same-cycle failure: that failure still reports
    applyStimulus(1'b0, 4'b0010, 1'b1, 2'b10, 4'b0010, 1'b1);
    idle(1, 1'b1);
    checkOutput("turn_ready_low", ctl_ready, 1'b0);
    applyStimulus(1'b0, 4'b0010, 1'b0, 2'b00, '0, 1'b1);
    idle(4, 1'b1);
    checkOutput("en_after_off", enabled_o, 4'b1101);
    drain();

    // Burst with backpressure and drops
    applyStimulus(1'b0, '0, 1'b1, 2'b01, 4'b1111, 1'b1);
    idle(1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'b1111, 1'b0, 2'b00, '0, 1'b0);
    idle(4, 1'b0);
    drain();

    // Kill while the FIFO is full
    applyStimulus(1'b0, 4'b1111, 1'b0, 2'b00, '0, 1'b0);
    idle(4, 1'b0);
    applyStimulus(1'b0, 4'b1100, 1'b0, 2'b00, '0, 1'b0);
    idle(1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 2'b11, 4'b0100, 1'b0);
    idle(1, 1'b0);
    checkOutput("kill_en2", enabled_o[2], 1'b0);
    checkOutput("kill_head_src", rpt_src, 0);
    drain();
    applyStimulus(1'b0, '0, 1'b1, 2'b01, 4'b0100, 1'b1);
    idle(1, 1'b1);

    // Reset while FIFO/pending are busy and the FSM is in TURN
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 4'b1111, 1'b0, 2'b00, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 2'b10, 4'b0011, 1'b0);
    applyStimulus(1'b1, '0, 1'b0, 2'b00, '0, 1'b0);
    idle(1, 1'b0);
    checkOutput("rst_rpt_valid", rpt_valid, 1'b0);
    checkOutput("rst_ctl_ready", ctl_ready, 1'b1);
    checkOutput("rst_enabled", enabled_o, 4'b1111);
    checkOutput("rst_drop", drop_cnt, 0);

    // Sequence wrap
    for (int i = 0; i < 65537; i++) applyStimulus(1'b0, 4'b0001, 1'b0, 2'b00, '0, 1'b1);
    drain();
    checkOutput("wrap_seq_a", h0, 65534);
    checkOutput("wrap_seq_b", h1, 65535);
    checkOutput("wrap_seq_c", h2, 0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [NS-1:0] f;
      for (int b = 0; b < NS; b++) f[b] = ($urandom_range(0, 4) == 0);
      applyStimulus(1'b0, f, $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
                    4'($urandom_range(0, 15)), $urandom_range(0, 2) != 0);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
